csc_rgb2ycbcr: RTL and testbench

CSC_RGB2YCBCR -- requirements
Module: csc_rgb2ycbcr

---
 rtl/csc_rgb2ycbcr.sv | 194 +++++++++++++++++++
 tb/tb_csc_rgb2ycbcr.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_rgb2ycbcr.sv
// csc_rgb2ycbcr: 4-stage RGB -> YCbCr colour-space converter with per-frame mode (BT.601 / bypass).
// Define CSC_BT709_EN to compile in the BT.709 coefficient set as mode 1.

module csc_rgb2ycbcr #(
    parameter int DW = 8,
    parameter int CF = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          per_img_vsync,
    input  logic          per_img_herf,
    input  logic          per_img_valid,
    input  logic [DW-1:0] per_img_red,
    input  logic [DW-1:0] per_img_green,
    input  logic [DW-1:0] per_img_blue,
    input  logic [1:0]    mode_sel,
    output logic          post_img_vsync,
    output logic          post_img_herf,
    output logic          post_img_valid,
    output logic [DW-1:0] post_img_Y,
    output logic [DW-1:0] post_img_Cb,
    output logic [DW-1:0] post_img_Cr,
    output logic [1:0]    mode_active
);

    localparam int ACCW = DW + CF + 3;

    typedef logic signed [ACCW-1:0] acc_t;
    typedef enum logic [1:0] {
        MODE_601    = 2'd0,
        MODE_709    = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Coefficients are given at 2^8 scale; rescale to 2^CF, rounding half away from zero.
    function automatic int scale_coef(input int c8);
        longint num;
        longint mag;
        num = longint'(c8) * (longint'(1) << CF);
        mag = (num < 0) ? -num : num;
        mag = (mag + 64'sd128) / 64'sd256;
        return (num < 0) ? -int'(mag) : int'(mag);
    endfunction

    localparam acc_t ZERO    = acc_t'(0);
    localparam acc_t ONE_PIX = acc_t'(longint'(1) << CF);
    localparam acc_t ROUND   = acc_t'(longint'(1) << (CF - 1));
    localparam acc_t OFFSET  = acc_t'(longint'(1) << (DW + CF - 1));
    localparam acc_t PIX_MAX = acc_t'((longint'(1) << DW) - 1);

    localparam acc_t C601_YR  = acc_t'(scale_coef(77));
    localparam acc_t C601_YG  = acc_t'(scale_coef(150));
    localparam acc_t C601_YB  = acc_t'(scale_coef(29));
    localparam acc_t C601_CBR = acc_t'(scale_coef(-43));
    localparam acc_t C601_CBG = acc_t'(scale_coef(-85));
    localparam acc_t C601_CBB = acc_t'(scale_coef(128));
    localparam acc_t C601_CRR = acc_t'(scale_coef(128));
    localparam acc_t C601_CRG = acc_t'(scale_coef(-107));
    localparam acc_t C601_CRB = acc_t'(scale_coef(-21));

`ifdef CSC_BT709_EN
    localparam acc_t C709_YR  = acc_t'(scale_coef(54));
    localparam acc_t C709_YG  = acc_t'(scale_coef(183));
    localparam acc_t C709_YB  = acc_t'(scale_coef(19));
    localparam acc_t C709_CBR = acc_t'(scale_coef(-29));
    localparam acc_t C709_CBG = acc_t'(scale_coef(-99));
    localparam acc_t C709_CBB = acc_t'(scale_coef(128));
    localparam acc_t C709_CRR = acc_t'(scale_coef(128));
    localparam acc_t C709_CRG = acc_t'(scale_coef(-116));
    localparam acc_t C709_CRB = acc_t'(scale_coef(-12));
`endif

    function automatic logic [DW-1:0] clamp_pix(input acc_t a);
        acc_t s;
        s = a >>> CF;
        if (s < ZERO)
            return '0;
        if (s > PIX_MAX)
            return '1;
        return s[DW-1:0];
    endfunction

    logic          vsync_q;
    logic          vsync_rise;
    mode_e         mode_cur;
    mode_e         mode_req;
    mode_e         pix_mode;
    mode_e         tag_s1;
    acc_t          pix     [3];
    acc_t          coef    [3][3];
    acc_t          prod_s1 [3][3];
    acc_t          acc_s2  [3];
    logic [DW-1:0] res_s3  [3];
    logic [3:0]    vsync_sr;
    logic [3:0]    herf_sr;
    logic [3:0]    valid_sr;

    // Unsupported requests (reserved, or 709 when not built in) fall back to BT.601.
    always_comb begin
        mode_req = MODE_601;
        case (mode_sel)
`ifdef CSC_BT709_EN
            2'd1:    mode_req = MODE_709;
`endif
            2'd2:    mode_req = MODE_BYPASS;
            default: mode_req = MODE_601;
        endcase
    end

    assign vsync_rise  = per_img_vsync & ~vsync_q;
    assign pix_mode    = vsync_rise ? mode_req : mode_cur;
    assign mode_active = mode_cur;

    assign pix[0] = acc_t'({{(ACCW-DW){1'b0}}, per_img_red});
    assign pix[1] = acc_t'({{(ACCW-DW){1'b0}}, per_img_green});
    assign pix[2] = acc_t'({{(ACCW-DW){1'b0}}, per_img_blue});

    // Bypass is an identity matrix so it shares the same datapath and latency.
    always_comb begin
        coef = '{'{C601_YR,  C601_YG,  C601_YB},
                 '{C601_CBR, C601_CBG, C601_CBB},
                 '{C601_CRR, C601_CRG, C601_CRB}};
        case (pix_mode)
`ifdef CSC_BT709_EN
            MODE_709: coef = '{'{C709_YR,  C709_YG,  C709_YB},
                               '{C709_CBR, C709_CBG, C709_CBB},
                               '{C709_CRR, C709_CRG, C709_CRB}};
`endif
            MODE_BYPASS: coef = '{'{ONE_PIX, ZERO, ZERO},
                                  '{ZERO, ONE_PIX, ZERO},
                                  '{ZERO, ZERO, ONE_PIX}};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            mode_cur <= MODE_601;
            tag_s1   <= MODE_601;
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 3; k++)
                    prod_s1[c][k] <= ZERO;
        end else begin
            vsync_q <= per_img_vsync;
            if (vsync_rise)
                mode_cur <= mode_req;
            tag_s1 <= pix_mode;
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 3; k++)
                    prod_s1[c][k] <= coef[c][k] * pix[k];
        end
    end

    // Chroma offset is skipped for bypass pixels, which is why the mode tag rides along to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                acc_s2[c] <= ZERO;
                res_s3[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                acc_s2[c] <= prod_s1[c][0] + prod_s1[c][1] + prod_s1[c][2] + ROUND
                             + (((c != 0) && (tag_s1 != MODE_BYPASS)) ? OFFSET : ZERO);
                res_s3[c] <= clamp_pix(acc_s2[c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_sr    <= '0;
            herf_sr     <= '0;
            valid_sr    <= '0;
            post_img_Y  <= '0;
            post_img_Cb <= '0;
            post_img_Cr <= '0;
        end else begin
            vsync_sr    <= {vsync_sr[2:0], per_img_vsync};
            herf_sr     <= {herf_sr[2:0], per_img_herf};
            valid_sr    <= {valid_sr[2:0], per_img_valid};
            post_img_Y  <= valid_sr[2] ? res_s3[0] : '0;
            post_img_Cb <= valid_sr[2] ? res_s3[1] : '0;
            post_img_Cr <= valid_sr[2] ? res_s3[2] : '0;
        end
    end

    assign post_img_vsync = vsync_sr[3];
    assign post_img_herf  = herf_sr[3];
    assign post_img_valid = valid_sr[3];

endmodule

// File: tb/tb_csc_rgb2ycbcr.sv
// tb_csc_rgb2ycbcr: directed-vector bench for csc_rgb2ycbcr (DW=8 instance plus a DW=10 bypass instance).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.

module tb_csc_rgb2ycbcr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs, hr, va;
    logic [7:0] r, g, b;
    logic [1:0] msel;
    logic       o_vs, o_hr, o_va;
    logic [7:0] o_y, o_cb, o_cr;
    logic [1:0] o_mode;

    logic       vs10, hr10, va10;
    logic [9:0] r10, g10, b10;
    logic [1:0] msel10;
    logic       o_vs10, o_hr10, o_va10;
    logic [9:0] o_y10, o_cb10, o_cr10;
    logic [1:0] o_mode10;

    int checks   = 0;
    int failures = 0;

    logic [23:0] vec_in  [4] = '{{8'd0, 8'd0, 8'd255}, {8'd100, 8'd150, 8'd200},
                                 {8'd0, 8'd255, 8'd0}, {8'd0, 8'd0, 8'd0}};
    logic [23:0] vec_exp [4] = '{{8'd29, 8'd255, 8'd107}, {8'd141, 8'd161, 8'd99},
                                 {8'd149, 8'd43, 8'd21}, {8'd0, 8'd128, 8'd128}};

    always #5 clk = ~clk;

    csc_rgb2ycbcr u_dut (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs), .per_img_herf(hr), .per_img_valid(va),
        .per_img_red(r), .per_img_green(g), .per_img_blue(b),
        .mode_sel(msel),
        .post_img_vsync(o_vs), .post_img_herf(o_hr), .post_img_valid(o_va),
        .post_img_Y(o_y), .post_img_Cb(o_cb), .post_img_Cr(o_cr),
        .mode_active(o_mode)
    );

    csc_rgb2ycbcr #(.DW(10), .CF(8)) u_dut10 (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs10), .per_img_herf(hr10), .per_img_valid(va10),
        .per_img_red(r10), .per_img_green(g10), .per_img_blue(b10),
        .mode_sel(msel10),
        .post_img_vsync(o_vs10), .post_img_herf(o_hr10), .post_img_valid(o_va10),
        .post_img_Y(o_y10), .post_img_Cb(o_cb10), .post_img_Cr(o_cr10),
        .mode_active(o_mode10)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic v, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        va = v; r = rr; g = gg; b = bb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vs = 0; hr = 0; msel = 2'd0; pix(0, 8'd0, 8'd0, 8'd0);
        vs10 = 0; hr10 = 0; va10 = 0; r10 = '0; g10 = '0; b10 = '0; msel10 = 2'd0;
        step(); step();
        checks++;
        if ({o_vs, o_hr, o_va, o_y, o_cb, o_cr, o_mode} !== 29'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", {o_vs, o_hr, o_va, o_y, o_cb, o_cr, o_mode});
        end
        checks++;
        if ({o_vs10, o_va10, o_y10, o_cb10, o_cr10, o_mode10} !== 34'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs_dw10 got=%h exp=0", {o_vs10, o_va10, o_y10, o_cb10, o_cr10, o_mode10});
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_bt601_white();
        vs = 1; hr = 1; msel = 2'd0; pix(1, 8'd255, 8'd255, 8'd255);
        step();
        pix(0, 8'd0, 8'd0, 8'd0);
        step(); step();
        checks++;
        if ({o_vs, o_va} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL white_early got=%b exp=00", {o_vs, o_va});
        end
        step();
        checks++;
        if ({o_vs, o_hr, o_va, o_y, o_cb, o_cr} !== {3'b111, 8'd255, 8'd128, 8'd128}) begin
            failures++;
            $display("[TB] FAIL white_pixel got=%h exp=%h", {o_vs, o_hr, o_va, o_y, o_cb, o_cr}, {3'b111, 8'd255, 8'd128, 8'd128});
        end
        step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr} !== 25'd0) begin
            failures++;
            $display("[TB] FAIL white_single_valid got=%h exp=0", {o_va, o_y, o_cb, o_cr});
        end
    endtask

    task automatic test_bt601_vectors();
        msel = 2'd2;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) pix(1, vec_in[i][23:16], vec_in[i][15:8], vec_in[i][7:0]);
            else       pix(0, 8'd0, 8'd0, 8'd0);
            step();
            if (i >= 3) begin
                checks++;
                if ({o_va, o_y, o_cb, o_cr, o_mode} !== {1'b1, vec_exp[i-3], 2'd0}) begin
                    failures++;
                    $display("[TB] FAIL bt601_vec%0d got=%h exp=%h", i - 3, {o_va, o_y, o_cb, o_cr, o_mode}, {1'b1, vec_exp[i-3], 2'd0});
                end
            end
        end
    endtask

    task automatic test_bypass8();
        vs = 0; step();
        vs = 1; msel = 2'd2; pix(1, 8'd12, 8'd34, 8'd56);
        step();
        pix(1, 8'd255, 8'd0, 8'd128);
        step();
        pix(0, 8'd0, 8'd0, 8'd0);
        step(); step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr, o_mode} !== {1'b1, 8'd12, 8'd34, 8'd56, 2'd2}) begin
            failures++;
            $display("[TB] FAIL bypass8_p0 got=%h exp=%h", {o_va, o_y, o_cb, o_cr, o_mode}, {1'b1, 8'd12, 8'd34, 8'd56, 2'd2});
        end
        step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr} !== {1'b1, 8'd255, 8'd0, 8'd128}) begin
            failures++;
            $display("[TB] FAIL bypass8_p1 got=%h exp=%h", {o_va, o_y, o_cb, o_cr}, {1'b1, 8'd255, 8'd0, 8'd128});
        end
    endtask

    task automatic test_reserved_mode();
        vs = 0; step();
        vs = 1; msel = 2'd3; pix(1, 8'd255, 8'd0, 8'd0);
        step();
        pix(0, 8'd0, 8'd0, 8'd0);
        step(); step(); step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr, o_mode} !== {1'b1, 8'd77, 8'd85, 8'd255, 2'd0}) begin
            failures++;
            $display("[TB] FAIL reserved_mode got=%h exp=%h", {o_va, o_y, o_cb, o_cr, o_mode}, {1'b1, 8'd77, 8'd85, 8'd255, 2'd0});
        end
    endtask

    task automatic test_back_to_back();
        vs = 0; step();
        vs = 1; msel = 2'd2; pix(1, 8'd12, 8'd34, 8'd56);
        step();
        vs = 0; pix(0, 8'd0, 8'd0, 8'd0);
        step();
        vs = 1; msel = 2'd0; pix(1, 8'd0, 8'd255, 8'd0);
        step();
        pix(0, 8'd0, 8'd0, 8'd0);
        step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr} !== {1'b1, 8'd12, 8'd34, 8'd56}) begin
            failures++;
            $display("[TB] FAIL b2b_bypass got=%h exp=%h", {o_va, o_y, o_cb, o_cr}, {1'b1, 8'd12, 8'd34, 8'd56});
        end
        step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr} !== 25'd0) begin
            failures++;
            $display("[TB] FAIL b2b_gap got=%h exp=0", {o_va, o_y, o_cb, o_cr});
        end
        step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr, o_mode} !== {1'b1, 8'd149, 8'd43, 8'd21, 2'd0}) begin
            failures++;
            $display("[TB] FAIL b2b_bt601 got=%h exp=%h", {o_va, o_y, o_cb, o_cr, o_mode}, {1'b1, 8'd149, 8'd43, 8'd21, 2'd0});
        end
    endtask

    task automatic test_mode1();
        logic [25:0] exp_px;
`ifdef CSC_BT709_EN
        exp_px = {8'd54, 8'd99, 8'd255, 2'd1};
`else
        exp_px = {8'd77, 8'd85, 8'd255, 2'd0};
`endif
        vs = 0; step();
        vs = 1; msel = 2'd1; pix(1, 8'd255, 8'd0, 8'd0);
        step();
        msel = 2'd0;
        step();
        pix(0, 8'd0, 8'd0, 8'd0);
        step(); step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr, o_mode} !== {1'b1, exp_px}) begin
            failures++;
            $display("[TB] FAIL mode1_p0 got=%h exp=%h", {o_va, o_y, o_cb, o_cr, o_mode}, {1'b1, exp_px});
        end
        step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr, o_mode} !== {1'b1, exp_px}) begin
            failures++;
            $display("[TB] FAIL mode1_p1_midframe got=%h exp=%h", {o_va, o_y, o_cb, o_cr, o_mode}, {1'b1, exp_px});
        end
    endtask

    task automatic test_bypass_dw10();
        vs10 = 1; hr10 = 1; msel10 = 2'd2; va10 = 1; r10 = 10'd1023; g10 = 10'd5; b10 = 10'd512;
        step();
        va10 = 0; r10 = 10'd7; g10 = 10'd7; b10 = 10'd7;
        step();
        va10 = 1; r10 = 10'd3; g10 = 10'd1000; b10 = 10'd77;
        step();
        checks++;
        if (o_va10 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dw10_early got=%b exp=0", o_va10);
        end
        va10 = 0; r10 = '0; g10 = '0; b10 = '0;
        step();
        checks++;
        if ({o_va10, o_y10, o_cb10, o_cr10, o_mode10} !== {1'b1, 10'd1023, 10'd5, 10'd512, 2'd2}) begin
            failures++;
            $display("[TB] FAIL dw10_p0 got=%h exp=%h", {o_va10, o_y10, o_cb10, o_cr10, o_mode10}, {1'b1, 10'd1023, 10'd5, 10'd512, 2'd2});
        end
        step();
        checks++;
        if ({o_va10, o_y10, o_cb10, o_cr10} !== 31'd0) begin
            failures++;
            $display("[TB] FAIL dw10_gap got=%h exp=0", {o_va10, o_y10, o_cb10, o_cr10});
        end
        step();
        checks++;
        if ({o_va10, o_y10, o_cb10, o_cr10} !== {1'b1, 10'd3, 10'd1000, 10'd77}) begin
            failures++;
            $display("[TB] FAIL dw10_p1 got=%h exp=%h", {o_va10, o_y10, o_cb10, o_cr10}, {1'b1, 10'd3, 10'd1000, 10'd77});
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        vs = 0; step();
        vs = 1; msel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            pix(1, 8'(10 + i), 8'(20 + i), 8'(30 + i));
            step();
        end
        checks++;
        if ({o_va, o_y, o_mode} !== {1'b1, 8'd10, 2'd2}) begin
            failures++;
            $display("[TB] FAIL pre_reset got=%h exp=%h", {o_va, o_y, o_mode}, {1'b1, 8'd10, 2'd2});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_vs, o_hr, o_va, o_y, o_cb, o_cr, o_mode} !== 29'd0) begin
            failures++;
            $display("[TB] FAIL async_reset got=%h exp=0", {o_vs, o_hr, o_va, o_y, o_cb, o_cr, o_mode});
        end
        vs = 0; hr = 0; pix(0, 8'd0, 8'd0, 8'd0);
        step(); step();
        #2 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_va !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("[TB] FAIL stale_after_reset got=%0d exp=0", stale);
        end
        vs = 1; hr = 1; msel = 2'd0; pix(1, 8'd255, 8'd255, 8'd255);
        step();
        pix(0, 8'd0, 8'd0, 8'd0);
        step(); step();
        checks++;
        if (o_va !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_early got=%b exp=0", o_va);
        end
        step();
        checks++;
        if ({o_va, o_y, o_cb, o_cr, o_mode} !== {1'b1, 8'd255, 8'd128, 8'd128, 2'd0}) begin
            failures++;
            $display("[TB] FAIL post_reset_first got=%h exp=%h", {o_va, o_y, o_cb, o_cr, o_mode}, {1'b1, 8'd255, 8'd128, 8'd128, 2'd0});
        end
    endtask

    initial begin
        test_reset();
        test_bt601_white();
        test_bt601_vectors();
        test_bypass8();
        test_reserved_mode();
        test_back_to_back();
        test_mode1();
        test_bypass_dw10();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
